// File: rtl/serial_echo_initiator.sv
// serial_echo_initiator
//   Host-side RS-232 (8N1) link self-test master. On a start request it sends one byte on
//   o_txd, then listens on i_rxd for the echoed byte and reports the result.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset (released synchronously inside)
//   i_start      one-cycle request, honoured only when idle
//   i_tx_byte    byte to send, captured when i_start is accepted
//   i_rxd        serial input from the responder (asynchronous, idles high)
//   o_txd        serial output to the responder (idles high)
//   o_busy       transaction in progress (SEND or WAIT)
//   o_done       one-cycle pulse ending every transaction
//   o_match      with o_done: echo received, stop bit good, byte equal to the sent one
//   o_timeout    with o_done: no echo start bit arrived inside the window
//   o_rx_byte    last received byte, held until the next reception
//   o_err_count  transactions ending without a match, saturating at 255
module serial_echo_initiator #(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_tx_byte,
    input  logic       i_rxd,
    output logic       o_txd,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_match,
    output logic       o_timeout,
    output logic [7:0] o_rx_byte,
    output logic [7:0] o_err_count
);

    // Bit period in clocks; must be at least 4 for the mid-bit sampling to make sense.
    localparam int unsigned DIV     = CLK_HZ / BAUD;
    localparam int unsigned HALF    = DIV / 2;
    localparam int unsigned TO_CLKS = TIMEOUT_BITS * DIV;
    localparam int unsigned BW      = $clog2(DIV);
    localparam int unsigned TW      = $clog2(TO_CLKS + 1);

    typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases on a clock edge.
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_e    r_state, w_state_next;
    rx_state_e r_rx_state, w_rx_state_next;

    logic          r_txd;
    logic [8:0]    r_tx_shift;   // d0..d7 then stop bit, shifted out LSB first
    logic [3:0]    r_tx_bit;     // 0 = start bit, 1..8 = data, 9 = stop bit
    logic [BW-1:0] r_tx_cnt;
    logic [7:0]    r_tx_data;

    logic [1:0]    r_rxd_sync;
    logic          r_rxd_prev;
    logic          r_rx_armed;
    logic          r_rx_done;
    logic          r_rx_stop_ok;
    logic [BW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic [7:0]    r_rx_byte;

    logic [TW-1:0] r_to_cnt;
    logic          r_match;
    logic          r_timeout;
    logic [7:0]    r_err_count;

    logic w_rxd;
    logic w_accept;
    logic w_tx_tick;
    logic w_tx_last;
    logic w_rx_tick;
    logic w_start_det;
    logic w_rx_idle;
    logic w_rx_finish;
    logic w_to_expire;
    logic w_match_next;
    logic w_enter_done;

    assign w_rxd        = r_rxd_sync[1];
    assign w_accept     = (r_state == StIdle) && i_start;
    assign w_tx_tick    = (r_tx_cnt == '0);
    assign w_tx_last    = (r_state == StSend) && w_tx_tick && (r_tx_bit == 4'd9);
    assign w_rx_tick    = (r_rx_cnt == '0);
    // r_rxd_prev is forced high on arming, so a line already held low yields one start.
    assign w_start_det  = r_rx_armed && (r_rx_state == RxIdle) && !w_rxd && r_rxd_prev;
    assign w_rx_idle    = (r_rx_state == RxIdle) && !w_start_det;
    assign w_rx_finish  = (r_rx_state == RxStop) && w_rx_tick;
    assign w_to_expire  = (r_state == StWait) && !r_rx_done && w_rx_idle &&
                          (r_to_cnt == TW'(1));
    assign w_match_next = r_rx_stop_ok && (r_rx_byte == r_tx_data);
    assign w_enter_done = (r_state == StWait) && (w_state_next == StDone);

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (i_start) w_state_next = StSend;
            // A frame already completed during SEND is reported only once TxD is idle.
            StSend:  if (w_tx_last) w_state_next = StWait;
            StWait:  if (r_rx_done || w_to_expire) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    assign o_busy = (r_state == StSend) || (r_state == StWait);
    assign o_done = (r_state == StDone);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_txd      <= 1'b1;
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
            r_tx_cnt   <= '0;
            r_tx_data  <= '0;
        end else if (w_accept) begin
            r_txd      <= 1'b0;
            r_tx_shift <= {1'b1, i_tx_byte};
            r_tx_bit   <= '0;
            r_tx_cnt   <= BW'(DIV - 1);
            r_tx_data  <= i_tx_byte;
        end else if (r_state == StSend) begin
            if (!w_tx_tick) begin
                r_tx_cnt <= r_tx_cnt - BW'(1);
            end else if (r_tx_bit != 4'd9) begin
                r_txd      <= r_tx_shift[0];
                r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                r_tx_bit   <= r_tx_bit + 4'd1;
                r_tx_cnt   <= BW'(DIV - 1);
            end
        end
    end

    assign o_txd = r_txd;

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_state <= RxIdle;
        end else begin
            r_rx_state <= w_rx_state_next;
        end
    end

    always_comb begin
        w_rx_state_next = r_rx_state;
        if (w_accept || (r_state == StDone)) begin
            w_rx_state_next = RxIdle;
        end else begin
            case (r_rx_state)
                RxIdle:  if (w_start_det) w_rx_state_next = RxStart;
                // Still low at mid start bit confirms the start; high means a glitch.
                RxStart: if (w_rx_tick) w_rx_state_next = w_rxd ? RxIdle : RxData;
                RxData:  if (w_rx_tick && (r_rx_bit == 3'd7)) w_rx_state_next = RxStop;
                RxStop:  if (w_rx_tick) w_rx_state_next = RxIdle;
                default: w_rx_state_next = RxIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver datapath
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rxd_sync   <= 2'b11;
            r_rxd_prev   <= 1'b1;
            r_rx_armed   <= 1'b0;
            r_rx_done    <= 1'b0;
            r_rx_stop_ok <= 1'b0;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_byte    <= '0;
        end else begin
            r_rxd_sync <= {r_rxd_sync[0], i_rxd};
            r_rxd_prev <= w_accept ? 1'b1 : w_rxd;

            // Only the first frame of a transaction counts.
            if (w_accept) begin
                r_rx_armed   <= 1'b1;
                r_rx_done    <= 1'b0;
                r_rx_stop_ok <= 1'b0;
            end else if (r_state == StDone) begin
                r_rx_armed <= 1'b0;
            end else if (w_rx_finish) begin
                r_rx_armed   <= 1'b0;
                r_rx_done    <= 1'b1;
                r_rx_stop_ok <= w_rxd;
                r_rx_byte    <= r_rx_shift;
            end

            // Idle preloads the half-bit delay so the first tick lands mid start bit.
            if (r_rx_state == RxIdle) begin
                r_rx_cnt <= BW'(HALF - 1);
                r_rx_bit <= '0;
            end else if (w_rx_tick) begin
                r_rx_cnt <= BW'(DIV - 1);
            end else begin
                r_rx_cnt <= r_rx_cnt - BW'(1);
            end

            if ((r_rx_state == RxData) && w_rx_tick) begin
                r_rx_shift <= {w_rxd, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
        end
    end

    assign o_rx_byte = r_rx_byte;

    // ------------------------------------------------------------------
    // Echo window and results
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_to_cnt <= '0;
        end else if (w_tx_last) begin
            r_to_cnt <= TW'(TO_CLKS);
        end else if ((r_state == StWait) && w_rx_idle && (r_to_cnt != '0)) begin
            // The window is frozen while a frame is being received.
            r_to_cnt <= r_to_cnt - TW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_match     <= 1'b0;
            r_timeout   <= 1'b0;
            r_err_count <= '0;
        end else if (w_accept) begin
            r_match   <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_enter_done) begin
            if (r_rx_done) begin
                r_match <= w_match_next;
            end else begin
                r_timeout <= 1'b1;
            end
            if (!(r_rx_done && w_match_next) && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign o_match     = r_match;
    assign o_timeout   = r_timeout;
    assign o_err_count = r_err_count;

endmodule
